// File: rtl/wb_slot_scheduler_if.sv
// Decode-side and writeback-side signal bundle for wb_slot_scheduler.
// The master drives decode and writeback observations and receives the issue/stall verdicts.
interface wb_slot_scheduler_if;
    logic       dec_valid_i;
    logic       dec_wr_en_i;
    logic [4:0] dec_write_addr_i;
    logic [1:0] dec_lat_sel_i;
    logic [4:0] dec_read_addr_a_i;
    logic [4:0] dec_read_addr_b_i;
    logic       dec_use_a_i;
    logic       dec_use_b_i;
    logic       wb_wr_en_i;
    logic [4:0] wb_addr_i;
    logic       issue_o;
    logic       stall_o;
    logic       wb_expect_valid_o;
    logic [4:0] wb_expect_addr_o;
    logic       wb_mismatch_o;
    logic [3:0] pending_cnt_o;

    modport master (
        output dec_valid_i, dec_wr_en_i, dec_write_addr_i, dec_lat_sel_i,
        output dec_read_addr_a_i, dec_read_addr_b_i, dec_use_a_i, dec_use_b_i,
        output wb_wr_en_i, wb_addr_i,
        input  issue_o, stall_o, wb_expect_valid_o, wb_expect_addr_o,
        input  wb_mismatch_o, pending_cnt_o
    );

    modport slave (
        input  dec_valid_i, dec_wr_en_i, dec_write_addr_i, dec_lat_sel_i,
        input  dec_read_addr_a_i, dec_read_addr_b_i, dec_use_a_i, dec_use_b_i,
        input  wb_wr_en_i, wb_addr_i,
        output issue_o, stall_o, wb_expect_valid_o, wb_expect_addr_o,
        output wb_mismatch_o, pending_cnt_o
    );
endinterface

// File: rtl/wb_slot_scheduler.sv
// Issue scheduler between decode and the fixed-latency back-end.
// A shifting reservation table (index = cycles until writeback) detects
// writeback-port conflicts, unbypassable RAW and WAW reordering, and
// cross-checks the actual writeback stream against the expected one.
module wb_slot_scheduler #(
    parameter int ALU_LAT = 2,
    parameter int MEM_LAT = 3,
    parameter int MUL_LAT = 7,
    parameter int DEPTH   = 8,
    parameter int BYP_IDX = 1
) (
    input  logic               clk_i,
    input  logic               rsn_i,
    wb_slot_scheduler_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic       valid;
        logic [4:0] addr;
    } entry_t;

    typedef enum logic [1:0] {
        LAT_ALU  = 2'd0,
        LAT_MEM  = 2'd1,
        LAT_MUL  = 2'd2,
        LAT_ALU2 = 2'd3
    } lat_sel_e;

    entry_t             tbl [DEPTH];
    logic [IDX_W-1:0]   lat;
    logic               rsv;
    logic               struct_hz;
    logic               raw_hz;
    logic               waw_hz;
    logic               stall;
    logic               issue;
    logic               mismatch_q;
    logic [3:0]         pending;

    // Hazard evaluation against the current (unshifted) table.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        lat       = IDX_W'(ALU_LAT);
        struct_hz = 1'b0;
        raw_hz    = 1'b0;
        waw_hz    = 1'b0;
        case (lat_sel_e'(bus.dec_lat_sel_i))
            LAT_MEM: lat = IDX_W'(MEM_LAT);
            LAT_MUL: lat = IDX_W'(MUL_LAT);
            default: lat = IDX_W'(ALU_LAT);
        endcase
        rsv       = bus.dec_wr_en_i & (bus.dec_write_addr_i != 5'd0);
        struct_hz = rsv & tbl[lat].valid;
        for (int k = 0; k < DEPTH; k++) begin
            if (tbl[k].valid) begin
                // Entries at or below BYP_IDX are forwarded by bypass_ctrl.
                if (k > BYP_IDX) begin
                    if (bus.dec_use_a_i && bus.dec_read_addr_a_i != 5'd0 &&
                        tbl[k].addr == bus.dec_read_addr_a_i)
                        raw_hz = 1'b1;
                    if (bus.dec_use_b_i && bus.dec_read_addr_b_i != 5'd0 &&
                        tbl[k].addr == bus.dec_read_addr_b_i)
                        raw_hz = 1'b1;
                end
                // An older write landing at or after our slot would overwrite us.
                if (rsv && IDX_W'(k) >= lat && tbl[k].addr == bus.dec_write_addr_i)
                    waw_hz = 1'b1;
            end
        end
        stall = bus.dec_valid_i & (struct_hz | raw_hz | waw_hz);
        issue = bus.dec_valid_i & ~stall;
    end

    // Shift the table every cycle and insert a new reservation at slot L-1.
    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            // NOTE: the table is reset explicitly because stale valid bits would cause false stalls.
            for (int k = 0; k < DEPTH; k++) tbl[k] <= '0;
            mismatch_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so the later insert overrides the shift of the same slot.
            for (int k = 0; k < DEPTH - 1; k++) tbl[k] <= tbl[k + 1];
            tbl[DEPTH - 1] <= '0;
            if (issue && rsv) tbl[lat - IDX_W'(1)] <= '{valid: 1'b1, addr: bus.dec_write_addr_i};
            mismatch_q <= (bus.wb_wr_en_i != tbl[0].valid) |
                          (bus.wb_wr_en_i & (bus.wb_addr_i != tbl[0].addr));
        end
    end

    // Count valid reservations.
    always_comb begin
        pending = '0;
        for (int k = 0; k < DEPTH; k++) pending = pending + 4'(tbl[k].valid);
    end

    assign bus.issue_o           = issue;
    assign bus.stall_o           = stall;
    assign bus.wb_expect_valid_o = tbl[0].valid;
    assign bus.wb_expect_addr_o  = tbl[0].valid ? tbl[0].addr : 5'd0;
    assign bus.wb_mismatch_o     = mismatch_q;
    assign bus.pending_cnt_o     = pending;

endmodule

// File: tb/tb_wb_slot_scheduler.sv
// Directed, table-driven bench for wb_slot_scheduler.
module tb_wb_slot_scheduler;

    logic clk = 1'b0;
    logic rsn = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    wb_slot_scheduler_if bus ();

    wb_slot_scheduler dut (
        .clk_i (clk),
        .rsn_i (rsn),
        .bus   (bus.slave)
    );

    typedef struct {
        string      name;
        logic       valid;
        logic       wr;
        logic [4:0] wa;
        logic [1:0] lat;
        logic [4:0] ra;
        logic       ua;
        logic [4:0] rb;
        logic       ub;
        logic       wbe;
        logic [4:0] wba;
        logic       e_issue;
        logic       e_stall;
        logic       e_ev;
        logic [4:0] e_ea;
        logic [3:0] e_cnt;
        logic       e_mis;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Decode offer with no writeback activity.
    task automatic dec(input string n, input int wr, wa, lat, ra, ua, rb, ub,
                       input int ei, es, ev, ea, cnt, mis);
        vec_t v;
        v.name = n; v.valid = 1'b1; v.wr = 1'(wr); v.wa = 5'(wa); v.lat = 2'(lat);
        v.ra = 5'(ra); v.ua = 1'(ua); v.rb = 5'(rb); v.ub = 1'(ub);
        v.wbe = 1'b0; v.wba = 5'd0;
        v.e_issue = 1'(ei); v.e_stall = 1'(es); v.e_ev = 1'(ev); v.e_ea = 5'(ea);
        v.e_cnt = 4'(cnt); v.e_mis = 1'(mis);
        vecs.push_back(v);
    endtask

    // No decode offer; optional writeback observation.
    task automatic idle(input string n, input int wbe, wba, ev, ea, cnt, mis);
        vec_t v;
        v.name = n; v.valid = 1'b0; v.wr = 1'b0; v.wa = 5'd0; v.lat = 2'd0;
        v.ra = 5'd0; v.ua = 1'b0; v.rb = 5'd0; v.ub = 1'b0;
        v.wbe = 1'(wbe); v.wba = 5'(wba);
        v.e_issue = 1'b0; v.e_stall = 1'b0; v.e_ev = 1'(ev); v.e_ea = 5'(ea);
        v.e_cnt = 4'(cnt); v.e_mis = 1'(mis);
        vecs.push_back(v);
    endtask

    // Drive one cycle's inputs, compare mid-cycle, then advance past the edge.
    task automatic apply(input vec_t v);
        bus.dec_valid_i       = v.valid;
        bus.dec_wr_en_i       = v.wr;
        bus.dec_write_addr_i  = v.wa;
        bus.dec_lat_sel_i     = v.lat;
        bus.dec_read_addr_a_i = v.ra;
        bus.dec_use_a_i       = v.ua;
        bus.dec_read_addr_b_i = v.rb;
        bus.dec_use_b_i       = v.ub;
        bus.wb_wr_en_i        = v.wbe;
        bus.wb_addr_i         = v.wba;
        #2;
        check({v.name, "/issue"},    32'(bus.issue_o),           32'(v.e_issue));
        check({v.name, "/stall"},    32'(bus.stall_o),           32'(v.e_stall));
        check({v.name, "/exp_vld"},  32'(bus.wb_expect_valid_o), 32'(v.e_ev));
        check({v.name, "/exp_addr"}, 32'(bus.wb_expect_addr_o),  32'(v.e_ea));
        check({v.name, "/pending"},  32'(bus.pending_cnt_o),     32'(v.e_cnt));
        check({v.name, "/mismatch"}, 32'(bus.wb_mismatch_o),     32'(v.e_mis));
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Structural conflict: MUL x5 occupies slot 2 when ALU x6 arrives at cycle 5.
        dec("st_mul5", 1, 5, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) idle("st_wait", 0, 0, 0, 0, 1, 0);
        dec("st_alu6_blk", 1, 6, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        dec("st_alu6_go",  1, 6, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        idle("st_wb5", 1, 5, 1, 5, 2, 0);
        idle("st_wb6", 1, 6, 1, 6, 1, 0);
        idle("st_empty", 0, 0, 0, 0, 0, 0);
        // RAW on a mult result: stalls until the entry reaches the bypass window.
        dec("raw_mul3", 1, 3, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) dec("raw_blk", 1, 10, 0, 3, 1, 0, 0, 0, 1, 0, 0, 1, 0);
        dec("raw_go", 1, 10, 0, 3, 1, 0, 0, 1, 0, 0, 0, 1, 0);
        idle("raw_wb3", 1, 3, 1, 3, 2, 0);
        idle("raw_wb10", 1, 10, 1, 10, 1, 0);
        dec("raw_mul3b", 1, 3, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        dec("raw_nouse", 1, 11, 0, 3, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        idle("raw_w1", 0, 0, 0, 0, 2, 0);
        idle("raw_wb11", 1, 11, 1, 11, 2, 0);
        for (int i = 0; i < 3; i++) idle("raw_w2", 0, 0, 0, 0, 1, 0);
        idle("raw_wb3b", 1, 3, 1, 3, 1, 0);
        // WAW: younger ALU x7 waits until the older MUL x7 is below slot L.
        dec("waw_mul7", 1, 7, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) dec("waw_blk", 1, 7, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        dec("waw_go", 1, 7, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        idle("waw_wb_a", 1, 7, 1, 7, 2, 0);
        idle("waw_wb_b", 1, 7, 1, 7, 1, 0);
        // x0 never reserves and never causes RAW.
        dec("x0_mul",  1, 0, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        dec("x0_read", 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        idle("x0_idle", 0, 0, 0, 0, 0, 0);
        // MEM latency and code 3 (ALU latency) contending for the same slot.
        dec("mem21",    1, 21, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        dec("alu3_blk", 1, 20, 3, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        dec("alu3_go",  1, 20, 3, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        idle("wb21", 1, 21, 1, 21, 2, 0);
        idle("wb20", 1, 20, 1, 20, 1, 0);
        // Writeback mismatches: wrong address, then a spurious write to an empty slot.
        dec("mis_alu4", 1, 4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        idle("mis_w",      0, 0, 0, 0, 1, 0);
        idle("mis_bad",    1, 9, 1, 4, 1, 0);
        idle("mis_pulse",  0, 0, 0, 0, 0, 1);
        idle("mis_spur",   1, 0, 0, 0, 0, 0);
        idle("mis_spur_p", 0, 0, 0, 0, 0, 1);
        idle("mis_clr",    0, 0, 0, 0, 0, 0);

        // Reset state: hold reset for two edges with no valid input.
        begin
            vec_t v;
            v = vecs[0];
            v.valid = 1'b0; v.wr = 1'b0;
            bus.dec_valid_i = 1'b0; bus.dec_wr_en_i = 1'b0; bus.dec_write_addr_i = '0;
            bus.dec_lat_sel_i = '0; bus.dec_read_addr_a_i = '0; bus.dec_read_addr_b_i = '0;
            bus.dec_use_a_i = 1'b0; bus.dec_use_b_i = 1'b0;
            bus.wb_wr_en_i = 1'b0; bus.wb_addr_i = '0;
            rsn = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            rsn = 1'b0;
            v.name = "reset"; v.e_issue = 1'b0; v.e_stall = 1'b0; v.e_ev = 1'b0;
            v.e_ea = 5'd0; v.e_cnt = 4'd0; v.e_mis = 1'b0;
            apply(v);
        end

        foreach (vecs[i]) apply(vecs[i]);

        // Reset mid-flight: three mult ops pending and a RAW-stalled reader via source B.
        vecs.delete();
        dec("rm_mul12", 1, 12, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        dec("rm_mul13", 1, 13, 2, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        dec("rm_mul14", 1, 14, 2, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0);
        dec("rm_raw_b", 0, 0, 0, 0, 0, 12, 1, 0, 1, 0, 0, 3, 0);
        dec("rm_after", 0, 0, 0, 0, 0, 12, 1, 1, 0, 0, 0, 0, 0);
        apply(vecs[0]);
        apply(vecs[1]);
        apply(vecs[2]);
        rsn = 1'b1;
        apply(vecs[3]);
        rsn = 1'b0;
        apply(vecs[4]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_slot_scheduler.md
Name: wb_slot_scheduler

Overview:
- Issue scheduler between decode and the back-end (exe / mult1-5 / cache / writeback latches).
- Keeps a reservation table of in-flight register writes, indexed by cycles-to-writeback.
- Stalls decode on three hazards:
  - writeback-port structural conflicts;
  - RAW on results not yet bypassable;
  - WAW reordering between short- and long-latency ops.
- Also cross-checks actual writebacks against the table.

Parameters:
- ALU_LAT, 2, cycles from issue to writeback for ALU ops
- MEM_LAT, 3, cycles from issue to writeback for cache loads
- MUL_LAT, 7, cycles from issue to writeback for mult ops (exe + mult1..5)
- DEPTH, 8, reservation table entries; must be > MUL_LAT
- BYP_IDX, 1, highest slot index whose data bypass_ctrl can forward

Ports:
- clk_i  in  1  clock, rising edge
- rsn_i  in  1  reset, synchronous, active-high
- dec_valid_i  in  1  decode holds a valid instruction
- dec_wr_en_i  in  1  instruction writes an integer register
- dec_write_addr_i  in  5  destination register
- dec_lat_sel_i  in  2  latency class: 0=ALU, 1=MEM, 2=MUL, 3=ALU
- dec_read_addr_a_i  in  5  source A
- dec_read_addr_b_i  in  5  source B
- dec_use_a_i  in  1  source A is read
- dec_use_b_i  in  1  source B is read
- wb_wr_en_i  in  1  actual writeback enable (writeback latch output)
- wb_addr_i  in  5  actual writeback address
- issue_o  out  1  instruction leaves decode this cycle
- stall_o  out  1  hold fetch/decode latches
- wb_expect_valid_o  out  1  table slot 0 valid
- wb_expect_addr_o  out  5  table slot 0 address
- wb_mismatch_o  out  1  registered; actual writeback disagreed with slot 0 last cycle
- pending_cnt_o  out  4  number of valid table entries

Behaviour:
- **Table:** DEPTH entries {valid, addr[4:0]}. Entry k valid at cycle t means writeback of addr in cycle t+k.
- **Latency select:** L = ALU_LAT / MEM_LAT / MUL_LAT from dec_lat_sel_i; code 3 uses ALU_LAT.
- **Reservation:** rsv = dec_wr_en_i & (dec_write_addr_i != 0). Writes to x0 never reserve.
- **Stall terms** (combinational, current table, before shift):
  - struct = rsv & entry[L].valid
  - raw = any k > BYP_IDX with entry[k].valid and addr == a source in use (use bit set, addr != 0)
  - waw = rsv & exists k >= L with entry[k].valid & entry[k].addr == dec_write_addr_i
- **Stall / issue:**
  - stall_o = dec_valid_i & (struct | raw | waw)
  - issue_o = dec_valid_i & ~stall_o
  - With dec_valid_i = 0, both outputs are 0.
- **Each edge:**
  - entry[k] <= entry[k+1] for k < DEPTH-1
  - entry[DEPTH-1] <= invalid
  - Then, if issue_o & rsv: entry[L-1] <= {1, dec_write_addr_i}. This slot is free because struct was 0.
- Entries always shift. The back-end never stalls, so an entry retires exactly L cycles after issue.
- **Outputs:**
  - wb_expect_valid_o / wb_expect_addr_o = entry[0] (combinational). addr is 0 when invalid.
  - wb_mismatch_o <= (wb_wr_en_i != entry[0].valid) | (wb_wr_en_i & wb_addr_i != entry[0].addr). Sticky-free; one pulse per bad cycle.
  - pending_cnt_o = popcount of valid entries (combinational).
- **Reset:** rsn_i high at an edge takes priority over issue and shift.
  - All entries invalid, addr 0, wb_mismatch_o = 0.
  - Hence stall_o = 0, pending_cnt_o = 0, wb_expect_* = 0.
  - A reset asserted while mult ops are in flight discards their reservations; the back-end latches are reset in the same cycle.
- **Simultaneous events:**
  - Retirement at slot 0 and a new reservation in the same edge are independent.
  - A RAW source equal to an entry at index <= BYP_IDX does not stall; bypass_ctrl covers it.
  - One stalled instruction re-evaluates every cycle with the shifted table.
- **No wrap-around:** slots beyond DEPTH-1 never exist because L <= DEPTH-1.

Test Plan:
- **Reset state:** hold rsn_i=1 for 2 cycles, then release with no valid input -> stall_o=0, issue_o=0, pending_cnt_o=0, wb_expect_valid_o=0, wb_mismatch_o=0.
- **Structural conflict:**
  - Issue MUL x5 at cycle 0 -> entry[6] = x5 at cycle 1.
  - Offer ALU x6 at cycle 5 (entry[2]=x5) -> stall_o=1 for that cycle.
  - Cycle 6 -> issue_o=1.
  - Writebacks: x5 at cycle 7, x6 at cycle 8.
- **RAW on mult:**
  - Issue MUL x3 at cycle 0.
  - Offer ALU reading x3 (use_a=1) at cycle 1 -> stall_o=1 for cycles 1..5.
  - issue_o=1 at cycle 6 (entry index 1).
  - Same source with use_a=0 -> no stall.
- **WAW:** issue MUL x7 at cycle 0; offer ALU writing x7 at cycle 1 -> stall until cycle 6 (older entry index 1 < L=2), then issue.
- **x0 handling:** MUL writing x0, then ALU reading x0 next cycle -> no reservation (pending_cnt_o stays 0), no stall.
- **Mismatch / reset mid-flight:**
  - Drive wb_wr_en_i=1, wb_addr_i=9 while entry[0] is x4 -> wb_mismatch_o=1 next cycle.
  - Assert rsn_i with 3 entries pending -> pending_cnt_o=0 next cycle, and a queued RAW stall clears.
